mips_cpu_bus_master: RTL

Avalon-MM master front end for the MIPS CPU. Serialises two core-side request channels, instruction fetch and data load/store, onto the single 32-bit Avalon bus that drives the memory slave. It generates byte enables and lane-replicated write data for byte, halfword and word stores, and extracts plus sign- or zero-extends load data. It honours `waitrequest` for any number of wait states.

---
 rtl/mips_cpu_bus_master.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_bus_master.sv
// mips_cpu_bus_master: Avalon-MM master front end for the MIPS core.
// Arbitrates instruction fetch and data load/store onto one 32-bit bus,
// steers byte lanes for sub-word stores and extends sub-word loads.
// Optional build macro: MISALIGN_CHECK_EN (reject misaligned half/word
// data accesses with dmem_err instead of issuing them aligned down).
module mips_cpu_bus_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic        ifetch_done,
    output logic [31:0] ifetch_instr,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [1:0]  dmem_size,
    input  logic        dmem_signed,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_done,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;

    // Avalon-side registers
    logic [31:0] r_address;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_writeData;
    logic [3:0]  r_byteEnable;

    // Core-side response registers
    logic        r_ifetchDone;
    logic [31:0] r_ifetchInstr;
    logic        r_dmemDone;
    logic [31:0] r_dmemRdata;
`ifdef MISALIGN_CHECK_EN
    logic        r_err;
`endif

    // Fields of the accepted request that are needed at completion
    logic        r_isData;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_offset;

    // Lane steering for the incoming data request
    logic [3:0]  w_reqByteEnable;
    logic [31:0] w_reqWriteData;
    logic        w_misaligned;

    // Extraction of the returned load data
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;
    logic [31:0] w_loadData;

    // Fetch addresses are word aligned, so their low bits carry nothing.
    logic        w_unusedFetchBits;
    assign w_unusedFetchBits = ^ifetch_addr[1:0];

    // Byte enables and replicated write data for the pending data request
    always_comb begin
        w_reqByteEnable = 4'b1111;
        w_reqWriteData  = dmem_wdata;
        case (dmem_size)
            2'b00: begin
                w_reqByteEnable = 4'b0001 << dmem_addr[1:0];
                w_reqWriteData  = {4{dmem_wdata[7:0]}};
            end
            2'b01: begin
                w_reqByteEnable = dmem_addr[1] ? 4'b1100 : 4'b0011;
                w_reqWriteData  = {2{dmem_wdata[15:0]}};
            end
            default: begin
            end
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    assign w_misaligned = ((dmem_size == 2'b01) && dmem_addr[0]) ||
                          (dmem_size[1] && (dmem_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Pick the addressed lane(s) out of readdata and sign/zero extend
    always_comb begin
        w_loadByte = readdata[7:0];
        case (r_offset)
            2'd1:    w_loadByte = readdata[15:8];
            2'd2:    w_loadByte = readdata[23:16];
            2'd3:    w_loadByte = readdata[31:24];
            default: w_loadByte = readdata[7:0];
        endcase
        w_loadHalf = r_offset[1] ? readdata[31:16] : readdata[15:0];
        w_loadData = readdata;
        case (r_size)
            2'b00:   w_loadData = {{24{r_signed & w_loadByte[7]}}, w_loadByte};
            2'b01:   w_loadData = {{16{r_signed & w_loadHalf[15]}}, w_loadHalf};
            default: w_loadData = readdata;
        endcase
    end

    // Request arbitration, bus handshake and response pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_address     <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_writeData   <= '0;
            r_byteEnable  <= '0;
            r_ifetchDone  <= 1'b0;
            r_ifetchInstr <= '0;
            r_dmemDone    <= 1'b0;
            r_dmemRdata   <= '0;
`ifdef MISALIGN_CHECK_EN
            r_err         <= 1'b0;
`endif
            r_isData      <= 1'b0;
            r_we          <= 1'b0;
            r_size        <= '0;
            r_signed      <= 1'b0;
            r_offset      <= '0;
        end else begin
            r_ifetchDone <= 1'b0;
            r_dmemDone   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dmem_req) begin
                        r_isData <= 1'b1;
                        r_we     <= dmem_we;
                        r_size   <= dmem_size;
                        r_signed <= dmem_signed;
                        r_offset <= dmem_addr[1:0];
                        if (w_misaligned) begin
                            r_dmemDone  <= 1'b1;
                            r_dmemRdata <= '0;
`ifdef MISALIGN_CHECK_EN
                            r_err       <= 1'b1;
`endif
                            r_state     <= RESP;
                        end else begin
                            r_address    <= {dmem_addr[31:2], 2'b00};
                            r_byteEnable <= w_reqByteEnable;
                            r_writeData  <= dmem_we ? w_reqWriteData : 32'd0;
                            r_read       <= ~dmem_we;
                            r_write      <= dmem_we;
                            r_state      <= BUS;
                        end
                    end else if (ifetch_req) begin
                        r_isData     <= 1'b0;
                        r_we         <= 1'b0;
                        r_size       <= 2'b10;
                        r_signed     <= 1'b0;
                        r_offset     <= 2'b00;
                        r_address    <= {ifetch_addr[31:2], 2'b00};
                        r_byteEnable <= 4'b1111;
                        r_writeData  <= '0;
                        r_read       <= 1'b1;
                        r_write      <= 1'b0;
                        r_state      <= BUS;
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_state <= RESP;
                        if (r_isData) begin
                            r_dmemDone  <= 1'b1;
                            r_dmemRdata <= r_we ? 32'd0 : w_loadData;
`ifdef MISALIGN_CHECK_EN
                            r_err       <= 1'b0;
`endif
                        end else begin
                            r_ifetchDone  <= 1'b1;
                            r_ifetchInstr <= readdata;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign address      = r_address;
    assign read         = r_read;
    assign write        = r_write;
    assign writedata    = r_writeData;
    assign byteenable   = r_byteEnable;
    assign ifetch_done  = r_ifetchDone;
    assign ifetch_instr = r_ifetchInstr;
    assign dmem_done    = r_dmemDone;
    assign dmem_rdata   = r_dmemRdata;
`ifdef MISALIGN_CHECK_EN
    assign dmem_err     = r_err;
`else
    assign dmem_err     = 1'b0;
`endif

endmodule
